uart_sample_rx: RTL and testbench

UART_SAMPLE_RX -- requirements
Module: uart_sample_rx

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_byte.sv | 139 +++++++++++++
 rtl/uart_sample_rx.sv | 144 ++++++++++++++
 tb/tb_uart_sample_rx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the sampled UART receiver: receiver state
// encoding and the derived timing/geometry constants.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  // Derived configuration: clock cycles per bit and bytes per sample.
  typedef struct packed {
    int div;
    int nbytes;
  } rx_cfg_t;

  function automatic rx_cfg_t calc_cfg(input int clk_freq, input int baud, input int sample_width);
    rx_cfg_t cfg;
    cfg.div    = clk_freq / baud;
    cfg.nbytes = (sample_width + 7) / 8;
    return cfg;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronises the serial line, times the start bit,
// samples eight data bits LSB first at mid-bit and checks the stop bit.
// Emits a one-cycle strobe with the byte, or a one-cycle frame error.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int DIV = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       strobe,
  output logic       frame_err,
  output logic       start,
  output logic       idle
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(DIV - 1);

  logic            sync_meta;
  logic            sync_line;
  logic [1:0]      fill;
  logic            armed;
  logic            armed_next;
  rx_state_t       state;
  rx_state_t       state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [2:0]      bit_idx;
  logic [2:0]      bit_next;
  logic [7:0]      shift;
  logic [7:0]      shift_next;

  // Two-flop synchroniser; idles high so reset never looks like a start bit.
  // The fill pipe marks when sync_line reflects the real line rather than
  // the reset value, so a line held low through reset is not taken as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      fill      <= 2'b00;
    end else begin
      sync_meta <= rx;
      sync_line <= sync_meta;
      fill      <= {fill[0], 1'b1};
    end
  end

  // State register and bit-timing datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      armed   <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      armed   <= armed_next;
    end
  end

  // Next-state, counter and strobe logic. A start is only accepted once the
  // line has been seen high (armed), which forces a genuine high-to-low edge.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    armed_next = armed;
    strobe     = 1'b0;
    frame_err  = 1'b0;
    start      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sync_line) begin
          armed_next = fill[1];
        end else if (armed) begin
          state_next = ST_START;
          cnt_next   = HALF;
          start      = 1'b1;
          armed_next = 1'b0;
        end
      end
      ST_START: begin
        if (cnt == '0) begin
          if (!sync_line) begin
            state_next = ST_DATA;
            cnt_next   = FULL;
            bit_next   = '0;
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt == '0) begin
          shift_next = {sync_line, shift[7:1]};
          cnt_next   = FULL;
          if (bit_idx == 3'd7) begin
            state_next = ST_STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      ST_STOP: begin
        if (cnt == '0) begin
          state_next = ST_IDLE;
          if (sync_line) begin
            strobe     = 1'b1;
            armed_next = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          cnt_next = cnt - 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign data = shift;
  assign idle = (state == ST_IDLE);

endmodule

// File: rtl/uart_sample_rx.sv
// Sample receiver: assembles little-endian bytes from uart_rx_byte into
// CHANNELS samples of SAMPLE_WIDTH bits, presents complete frames through a
// valid/ready holding register, and discards stale partial frames on timeout.
module uart_sample_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int BAUD         = 115_200,
  parameter int SAMPLE_WIDTH = 18,
  parameter int CHANNELS     = 1,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                             CLK_IN,
  input  logic                             RSTN_i,
  input  logic                             RS232_RX_i,
  output logic [CHANNELS*SAMPLE_WIDTH-1:0] SAMPLE_o,
  output logic                             VALID_o,
  input  logic                             READY_i,
  output logic                             FRAME_ERR_o,
  output logic                             OVERRUN_o,
  output logic                             TIMEOUT_o
);

  localparam rx_cfg_t CFG    = calc_cfg(CLK_FREQ, BAUD, SAMPLE_WIDTH);
  localparam int      DIV    = CFG.div;
  localparam int      NBYTES = CFG.nbytes;
  localparam int      TOTAL  = NBYTES * CHANNELS;
  localparam int      IDX_W  = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int      LIMIT  = TIMEOUT_BITS * DIV;
  localparam int      TW     = $clog2(LIMIT + 1);
  localparam int      FW     = CHANNELS * SAMPLE_WIDTH;

  logic [7:0]       byte_data;
  logic             byte_strobe;
  logic             byte_err;
  logic             byte_start;
  logic             rx_idle;
  logic [IDX_W-1:0] idx;
  logic [TW-1:0]    idle_cnt;
  logic [FW-1:0]    frame_q;
  logic [FW-1:0]    frame_next;
  logic [FW-1:0]    sample_q;
  logic             valid_q;
  logic             frame_err_q;
  logic             overrun_q;
  logic             timeout_q;
  logic             frame_done;
  int               cur_sample;
  int               cur_byte;

  uart_rx_byte #(
    .DIV(DIV)
  ) u_rx_byte (
    .clk      (CLK_IN),
    .rst_n    (RSTN_i),
    .rx       (RS232_RX_i),
    .data     (byte_data),
    .strobe   (byte_strobe),
    .frame_err(byte_err),
    .start    (byte_start),
    .idle     (rx_idle)
  );

  // Merge the arriving byte into the frame being assembled; bits of the last
  // byte of a sample beyond SAMPLE_WIDTH have no destination and are dropped.
  always_comb begin
    cur_sample = int'(idx) / NBYTES;
    cur_byte   = int'(idx) % NBYTES;
    frame_next = frame_q;
    if (byte_strobe) begin
      for (int c = 0; c < CHANNELS; c++) begin
        for (int j = 0; j < SAMPLE_WIDTH; j++) begin
          if (c == cur_sample && (j / 8) == cur_byte) begin
            frame_next[c*SAMPLE_WIDTH + j] = byte_data[j % 8];
          end
        end
      end
    end
  end

  assign frame_done = byte_strobe && (idx == IDX_W'(TOTAL - 1));

  // Byte index, assembly register and idle timeout. Stop handling only
  // happens outside IDLE, so it never competes with the timeout branch.
  always_ff @(posedge CLK_IN or negedge RSTN_i) begin
    if (!RSTN_i) begin
      idx       <= '0;
      idle_cnt  <= '0;
      frame_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      frame_q   <= frame_next;
      if (byte_err) begin
        idx      <= '0;
        idle_cnt <= '0;
      end else if (byte_strobe) begin
        idx      <= frame_done ? '0 : idx + IDX_W'(1);
        idle_cnt <= '0;
      end else if (byte_start || idx == '0) begin
        idle_cnt <= '0;
      end else if (rx_idle) begin
        if (idle_cnt == TW'(LIMIT - 1)) begin
          idle_cnt  <= '0;
          idx       <= '0;
          timeout_q <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TW'(1);
        end
      end
    end
  end

  // Holding register with valid/ready handshake; a frame arriving while the
  // previous one is still unconsumed is dropped and reported as an overrun.
  always_ff @(posedge CLK_IN or negedge RSTN_i) begin
    if (!RSTN_i) begin
      sample_q    <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      overrun_q   <= 1'b0;
      frame_err_q <= byte_err;
      if (frame_done) begin
        if (!valid_q || READY_i) begin
          sample_q <= frame_next;
          valid_q  <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && READY_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign SAMPLE_o    = sample_q;
  assign VALID_o     = valid_q;
  assign FRAME_ERR_o = frame_err_q;
  assign OVERRUN_o   = overrun_q;
  assign TIMEOUT_o   = timeout_q;

endmodule

// File: tb/tb_uart_sample_rx.sv
// Bench for uart_sample_rx: drives 8N1 bytes, predicts delivered frames from
// the byte stream with plain arithmetic and checks the handshake every cycle.
module tb_uart_sample_rx;

  localparam int DIV = 104;
  localparam int SW  = 18;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line1;
  logic        line2;
  logic        ready1;
  logic        ready2;
  logic [17:0] sample1;
  logic        valid1;
  logic        ferr1;
  logic        ovr1;
  logic        tmo1;
  logic [35:0] sample2;
  logic        valid2;
  logic        ferr2;
  logic        ovr2;
  logic        tmo2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int last_rise = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int tmo_cnt = 0;
  int rise2_cnt = 0;
  int exp_q[$];
  int hold = 0;
  bit have_hold = 1'b0;
  bit need_new = 1'b0;
  logic prev_ferr = 1'b0;
  logic prev_ovr = 1'b0;
  logic prev_tmo = 1'b0;
  logic prev_valid2 = 1'b0;
  logic [35:0] exp2;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_sample_rx dut1 (
    .CLK_IN     (clk),
    .RSTN_i     (rst_n),
    .RS232_RX_i (line1),
    .SAMPLE_o   (sample1),
    .VALID_o    (valid1),
    .READY_i    (ready1),
    .FRAME_ERR_o(ferr1),
    .OVERRUN_o  (ovr1),
    .TIMEOUT_o  (tmo1)
  );

  uart_sample_rx #(
    .CHANNELS(2)
  ) dut2 (
    .CLK_IN     (clk),
    .RSTN_i     (rst_n),
    .RS232_RX_i (line2),
    .SAMPLE_o   (sample2),
    .VALID_o    (valid2),
    .READY_i    (ready2),
    .FRAME_ERR_o(ferr2),
    .OVERRUN_o  (ovr2),
    .TIMEOUT_o  (tmo2)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected sample value from three little-endian bytes, upper bits dropped.
  function automatic int frame_value(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    int v;
    v = (int'(b2) << 16) | (int'(b1) << 8) | int'(b0);
    return v & ((1 << SW) - 1);
  endfunction

  // Per-cycle comparison against the frame model and flag pulse tracking.
  always @(negedge clk) begin
    if (!rst_n) begin
      have_hold = 1'b0;
      need_new  = 1'b0;
    end else begin
      if (valid1) begin
        if (!have_hold || need_new) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_valid", 64'(valid1), 64'd0);
          end else begin
            hold      = exp_q.pop_front();
            have_hold = 1'b1;
            last_rise = cyc;
          end
        end
        if (have_hold) checkOutput("sample_vs_model", 64'(sample1), 64'(hold));
      end else begin
        have_hold = 1'b0;
      end
      need_new = valid1 && ready1;
    end
    if (ferr1) begin
      checkOutput("frame_err_width", 64'(prev_ferr), 64'd0);
      if (!prev_ferr) ferr_cnt++;
    end
    if (ovr1) begin
      checkOutput("overrun_width", 64'(prev_ovr), 64'd0);
      if (!prev_ovr) ovr_cnt++;
    end
    if (tmo1) begin
      checkOutput("timeout_width", 64'(prev_tmo), 64'd0);
      if (!prev_tmo) tmo_cnt++;
    end
    if (valid2 && !prev_valid2) rise2_cnt++;
    prev_ferr   = ferr1;
    prev_ovr    = ovr1;
    prev_tmo    = tmo1;
    prev_valid2 = valid2;
  end

  task automatic drive(input int which, input logic v);
    if (which == 1) line1 = v;
    else line2 = v;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int which, input logic [7:0] b, input bit stop_ok);
    @(posedge clk);
    #1;
    if (which == 1) last_start = cyc;
    drive(which, 1'b0);
    for (int i = 0; i < 8; i++) drive(which, b[i]);
    drive(which, stop_ok);
    if (!stop_ok) drive(which, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input bit deliver);
    if (deliver) exp_q.push_back(frame_value(b0, b1, b2));
    applyStimulus(1, b0, 1'b1);
    applyStimulus(1, b1, 1'b1);
    applyStimulus(1, b2, 1'b1);
  endtask

  task automatic ready_pulse();
    @(posedge clk);
    #1 ready1 = 1'b1;
    @(posedge clk);
    #1 ready1 = 1'b0;
    checkOutput("valid_after_ready", 64'(valid1), 64'd0);
  endtask

  initial begin
    rst_n  = 1'b0;
    line1  = 1'b1;
    line2  = 1'b1;
    ready1 = 1'b0;
    ready2 = 1'b0;
    exp2   = {18'd261, 18'd440};
    repeat (5) @(posedge clk);
    #1;
    checkOutput("reset_sample", 64'(sample1), 64'd0);
    checkOutput("reset_valid", 64'(valid1), 64'd0);
    checkOutput("reset_flags", 64'({ferr1, ovr1, tmo1}), 64'd0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Basic frame 440 and hold-until-ready
    send_frame(8'hB8, 8'h01, 8'h00, 1'b1);
    checkOutput("valid_latency", 64'(last_rise - last_start), 64'd991);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("valid_held", 64'(valid1), 64'd1);
    checkOutput("sample_440", 64'(sample1), 64'd440);
    ready_pulse();

    // Two-channel instance: 440 then 261
    applyStimulus(2, 8'hB8, 1'b1);
    applyStimulus(2, 8'h01, 1'b1);
    applyStimulus(2, 8'h00, 1'b1);
    checkOutput("ch2_no_early_valid", 64'(valid2), 64'd0);
    applyStimulus(2, 8'h05, 1'b1);
    applyStimulus(2, 8'h01, 1'b1);
    applyStimulus(2, 8'h00, 1'b1);
    checkOutput("ch2_valid", 64'(valid2), 64'd1);
    checkOutput("ch2_sample", 64'(sample2), 64'(exp2));
    checkOutput("ch2_single_valid", 64'(rise2_cnt), 64'd1);

    // Frame error after one good byte, then clean 293
    applyStimulus(1, 8'h25, 1'b1);
    applyStimulus(1, 8'h7F, 1'b0);
    checkOutput("frame_err_count", 64'(ferr_cnt), 64'd1);
    send_frame(8'h25, 8'h01, 8'h00, 1'b1);
    checkOutput("sample_293", 64'(sample1), 64'd293);
    ready_pulse();

    // Timeout after two bytes, then clean 329
    applyStimulus(1, 8'h49, 1'b1);
    applyStimulus(1, 8'h01, 1'b1);
    repeat (21 * DIV) @(posedge clk);
    #1;
    checkOutput("timeout_count", 64'(tmo_cnt), 64'd1);
    checkOutput("timeout_no_valid", 64'(valid1), 64'd0);
    send_frame(8'h49, 8'h01, 8'h00, 1'b1);
    checkOutput("sample_329", 64'(sample1), 64'd329);
    ready_pulse();

    // Overrun: 349 kept, 391 dropped
    send_frame(8'h5D, 8'h01, 8'h00, 1'b1);
    send_frame(8'h87, 8'h01, 8'h00, 1'b0);
    checkOutput("overrun_count", 64'(ovr_cnt), 64'd1);
    checkOutput("overrun_sample", 64'(sample1), 64'd349);
    checkOutput("overrun_valid", 64'(valid1), 64'd1);
    ready_pulse();

    // Frame completes in the same cycle as a transfer; top bits of byte2 ignored
    send_frame(8'h2C, 8'h01, 8'h00, 1'b1);
    exp_q.push_back(frame_value(8'h34, 8'h12, 8'hFE));
    applyStimulus(1, 8'h34, 1'b1);
    applyStimulus(1, 8'h12, 1'b1);
    fork
      applyStimulus(1, 8'hFE, 1'b1);
      begin
        @(posedge clk);
        repeat (990) @(posedge clk);
        #1 ready1 = 1'b1;
        @(posedge clk);
        #1 ready1 = 1'b0;
      end
    join
    checkOutput("coincident_valid", 64'(valid1), 64'd1);
    checkOutput("coincident_sample", 64'(sample1), 64'd135732);
    ready_pulse();

    // Short low glitch must not produce a byte
    @(posedge clk);
    #1 line1 = 1'b0;
    repeat (30) @(posedge clk);
    #1 line1 = 1'b1;
    repeat (3 * DIV) @(posedge clk);
    #1;
    checkOutput("glitch_no_valid", 64'(valid1), 64'd0);
    checkOutput("glitch_no_ferr", 64'(ferr_cnt), 64'd1);

    // Reset mid-byte with a frame pending; line held low across release
    send_frame(8'h2C, 8'h01, 8'h00, 1'b1);
    checkOutput("pre_reset_sample", 64'(sample1), 64'd300);
    @(posedge clk);
    #1 line1 = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset_sample", 64'(sample1), 64'd0);
    checkOutput("midreset_valid", 64'(valid1), 64'd0);
    checkOutput("midreset_flags", 64'({ferr1, ovr1, tmo1}), 64'd0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1200) @(posedge clk);
    #1;
    checkOutput("held_low_no_ferr", 64'(ferr_cnt), 64'd1);
    checkOutput("held_low_no_valid", 64'(valid1), 64'd0);
    line1 = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    send_frame(8'hC3, 8'hA5, 8'h02, 1'b1);
    checkOutput("post_reset_sample", 64'(sample1), 64'd173507);
    ready_pulse();

    repeat (20) @(posedge clk);
    #1;
    checkOutput("model_queue_empty", 64'(exp_q.size()), 64'd0);
    checkOutput("final_flag_counts", 64'({ovr_cnt[7:0], tmo_cnt[7:0]}), 64'h0101);
    checkOutput("ch2_no_flags", 64'({ferr2, ovr2, tmo2}), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
